// File: rtl/iic_mas_buf.sv
// Byte buffer and bit-rate stage in front of the IIC master: clk_ref divider,
// TX/RX byte FIFOs driven by the master's byte-boundary strobe, and an
// auto-release pulse for master_rw_done.
module iic_mas_buf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [15:0]   prescale,
  input  logic          fifo_clr,
  input  logic          tx_wr,
  input  logic [7:0]    tx_wdata,
  input  logic          rx_rd,
  output logic [7:0]    rx_rdata,
  output logic [AW:0]   tx_level,
  output logic [AW:0]   rx_level,
  output logic          tx_full,
  output logic          rx_empty,
  output logic          tx_underrun,
  output logic          rx_overflow,
  input  logic          err_clr,
  input  logic [3:0]    cpu_command,
  input  logic          mast_iic_rw1,
  input  logic          master_rw_done,
  input  logic [7:0]    data_iicm_2_8032,
  output logic [7:0]    data_8032_2_iicm,
  output logic          rel_mst_rw,
  output logic          clk_ref
);

  localparam logic [AW:0] FullLvl = (AW + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Reference clock divider
  // ---------------------------------------------------------------------------
  logic [15:0] div_cnt_q, div_cnt_d;
  logic        clk_ref_q, clk_ref_d;

  // Count up to prescale, then wrap and toggle; a lowered prescale simply
  // forces the next cycle to be a toggle, so no sub-cycle pulse can appear.
  always_comb begin
    div_cnt_d = div_cnt_q + 16'd1;
    clk_ref_d = clk_ref_q;
    if (div_cnt_q >= prescale) begin
      div_cnt_d = '0;
      clk_ref_d = ~clk_ref_q;
    end
  end

  // Divider state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      clk_ref_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      clk_ref_q <= clk_ref_d;
    end
  end

  assign clk_ref = clk_ref_q;

  // ---------------------------------------------------------------------------
  // Edge detect on the byte strobe and on master_rw_done
  // ---------------------------------------------------------------------------
  logic rw1_q, rw_evt_q;
  logic done_q, rel_q;

  // One registered event per rising edge, regardless of how long the level lasts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rw1_q    <= 1'b0;
      rw_evt_q <= 1'b0;
      done_q   <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      rw1_q    <= mast_iic_rw1;
      rw_evt_q <= mast_iic_rw1 & ~rw1_q;
      done_q   <= master_rw_done;
      rel_q    <= master_rw_done & ~done_q;
    end
  end

  assign rel_mst_rw = rel_q;

  // ---------------------------------------------------------------------------
  // Transfer control
  // ---------------------------------------------------------------------------
  logic wr_mode, rd_mode;
  logic tx_empty, rx_full;
  logic tx_pop_req, tx_pop, tx_push;
  logic rx_push_req, rx_push, rx_pop;

  assign wr_mode = (cpu_command[1:0] == 2'b01);
  assign rd_mode = cpu_command[1];

  logic [AW:0] tx_lvl_q, tx_lvl_d;
  logic [AW:0] rx_lvl_q, rx_lvl_d;

  assign tx_empty = (tx_lvl_q == '0);
  assign tx_full  = (tx_lvl_q == FullLvl);
  assign rx_empty = (rx_lvl_q == '0);
  assign rx_full  = (rx_lvl_q == FullLvl);

  // A flush wins over every push and pop in the same cycle.
  assign tx_pop_req  = rw_evt_q & wr_mode & ~fifo_clr;
  assign tx_pop      = tx_pop_req & ~tx_empty;
  assign tx_push     = tx_wr & ~tx_full & ~fifo_clr;
  assign rx_push_req = rw_evt_q & rd_mode & ~fifo_clr;
  assign rx_push     = rx_push_req & ~rx_full;
  assign rx_pop      = rx_rd & ~rx_empty & ~fifo_clr;

  // ---------------------------------------------------------------------------
  // FIFO pointers, levels, flags and the transmit data register
  // ---------------------------------------------------------------------------
  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic          tx_underrun_q, tx_underrun_d;
  logic          rx_overflow_q, rx_overflow_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    rx_mem_q [DEPTH];

  // Next-state for pointers and levels; pointers wrap naturally at DEPTH.
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    tx_lvl_d    = tx_lvl_q;
    rx_lvl_d    = rx_lvl_q;
    if (fifo_clr) begin
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      tx_lvl_d    = '0;
      rx_lvl_d    = '0;
    end else begin
      if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + 1'b1;
      if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
      if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + 1'b1;
      if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
      if (tx_push && !tx_pop) tx_lvl_d = tx_lvl_q + 1'b1;
      if (!tx_push && tx_pop) tx_lvl_d = tx_lvl_q - 1'b1;
      if (rx_push && !rx_pop) rx_lvl_d = rx_lvl_q + 1'b1;
      if (!rx_push && rx_pop) rx_lvl_d = rx_lvl_q - 1'b1;
    end
  end

  // Sticky error flags; either clear beats a same-cycle set.
  always_comb begin
    tx_underrun_d = tx_underrun_q;
    rx_overflow_d = rx_overflow_q;
    if (fifo_clr || err_clr) begin
      tx_underrun_d = 1'b0;
      rx_overflow_d = 1'b0;
    end else begin
      if (tx_pop_req && tx_empty) tx_underrun_d = 1'b1;
      if (rx_push_req && rx_full) rx_overflow_d = 1'b1;
    end
  end

  // Transmit byte register: loads only on a real pop, so a flush leaves it alone.
  always_comb begin
    tx_data_d = tx_data_q;
    if (tx_pop) tx_data_d = tx_mem_q[tx_rd_ptr_q];
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wr_ptr_q   <= '0;
      tx_rd_ptr_q   <= '0;
      rx_wr_ptr_q   <= '0;
      rx_rd_ptr_q   <= '0;
      tx_lvl_q      <= '0;
      rx_lvl_q      <= '0;
      tx_underrun_q <= 1'b0;
      rx_overflow_q <= 1'b0;
      tx_data_q     <= 8'h00;
    end else begin
      tx_wr_ptr_q   <= tx_wr_ptr_d;
      tx_rd_ptr_q   <= tx_rd_ptr_d;
      rx_wr_ptr_q   <= rx_wr_ptr_d;
      rx_rd_ptr_q   <= rx_rd_ptr_d;
      tx_lvl_q      <= tx_lvl_d;
      rx_lvl_q      <= rx_lvl_d;
      tx_underrun_q <= tx_underrun_d;
      rx_overflow_q <= rx_overflow_d;
      tx_data_q     <= tx_data_d;
    end
  end

  // Storage arrays; cleared on reset so no stale byte survives a mid-transfer reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tx_mem_q[i] <= 8'h00;
        rx_mem_q[i] <= 8'h00;
      end
    end else begin
      if (tx_push) tx_mem_q[tx_wr_ptr_q] <= tx_wdata;
      if (rx_push) rx_mem_q[rx_wr_ptr_q] <= data_iicm_2_8032;
    end
  end

  assign tx_level         = tx_lvl_q;
  assign rx_level         = rx_lvl_q;
  assign tx_underrun      = tx_underrun_q;
  assign rx_overflow      = rx_overflow_q;
  assign data_8032_2_iicm = tx_data_q;
  // Show-ahead head of RX, forced to zero when nothing is stored.
  assign rx_rdata         = rx_empty ? 8'h00 : rx_mem_q[rx_rd_ptr_q];

endmodule

// File: tb/tb_iic_mas_buf.sv
// Self-checking bench for iic_mas_buf: stimulus pushes expected bytes into
// scoreboard queues, a negedge monitor pops and compares when the DUT presents them.
module tb_iic_mas_buf;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [15:0]   prescale;
  logic          fifo_clr, tx_wr, rx_rd, err_clr;
  logic [7:0]    tx_wdata;
  logic [7:0]    rx_rdata;
  logic [AW:0]   tx_level, rx_level;
  logic          tx_full, rx_empty, tx_underrun, rx_overflow;
  logic [3:0]    cpu_command;
  logic          mast_iic_rw1, master_rw_done;
  logic [7:0]    data_iicm_2_8032, data_8032_2_iicm;
  logic          rel_mst_rw, clk_ref;

  always #5 clk = ~clk;

  iic_mas_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .prescale         (prescale),
    .fifo_clr         (fifo_clr),
    .tx_wr            (tx_wr),
    .tx_wdata         (tx_wdata),
    .rx_rd            (rx_rd),
    .rx_rdata         (rx_rdata),
    .tx_level         (tx_level),
    .rx_level         (rx_level),
    .tx_full          (tx_full),
    .rx_empty         (rx_empty),
    .tx_underrun      (tx_underrun),
    .rx_overflow      (rx_overflow),
    .err_clr          (err_clr),
    .cpu_command      (cpu_command),
    .mast_iic_rw1     (mast_iic_rw1),
    .master_rw_done   (master_rw_done),
    .data_iicm_2_8032 (data_iicm_2_8032),
    .data_8032_2_iicm (data_8032_2_iicm),
    .rel_mst_rw       (rel_mst_rw),
    .clk_ref          (clk_ref)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       uf;
  } tx_exp_t;

  tx_exp_t    tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [7:0] tx_model[$];
  logic [7:0] cur_data;
  logic       uf_m;
  int         rx_lvl_m;
  int         total = 0;
  int         bad   = 0;
  int         tx_due = 0;
  int         rel_cnt = 0;
  logic       rw1_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: the TX byte is due two cycles after a write-mode strobe rises.
  always @(negedge clk) begin : monitor
    tx_exp_t e;
    if (tx_due > 0) begin
      tx_due--;
      if (tx_due == 0) begin
        if (tx_exp.size() == 0) check("tx_sb_empty", 1, 0);
        else begin
          e = tx_exp.pop_front();
          check("tx_byte", data_8032_2_iicm, e.data);
          check("tx_underrun_flag", tx_underrun, e.uf);
        end
      end
    end
    if (reset_n && mast_iic_rw1 && !rw1_prev && cpu_command[1:0] == 2'b01) tx_due = 2;
    rw1_prev = mast_iic_rw1;
    if (rx_rd) begin
      if (rx_exp.size() == 0) check("rx_sb_empty", 1, 0);
      else check("rx_byte", rx_rdata, rx_exp.pop_front());
    end
    if (rel_mst_rw) rel_cnt++;
  end

  task automatic model_clear();
    tx_model.delete();
    rx_exp.delete();
    rx_lvl_m = 0;
    uf_m     = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_wr = 1'b1;
    tx_wdata = b;
    if (tx_model.size() < DEPTH) tx_model.push_back(b);
    tick(1);
    tx_wr = 1'b0;
  endtask

  task automatic strobe(input int hi, input int lo, input logic [7:0] rdata);
    if (cpu_command[1:0] == 2'b01) begin
      if (tx_model.size() > 0) cur_data = tx_model.pop_front();
      else uf_m = 1'b1;
      tx_exp.push_back({cur_data, uf_m});
    end else if (cpu_command[1]) begin
      if (rx_lvl_m < DEPTH) begin
        rx_exp.push_back(rdata);
        rx_lvl_m++;
      end
    end
    data_iicm_2_8032 = rdata;
    mast_iic_rw1 = 1'b1;
    tick(hi);
    mast_iic_rw1 = 1'b0;
    tick(lo);
  endtask

  task automatic meas_half(input int exp, input string name);
    logic lv;
    int   n;
    lv = clk_ref;
    n  = 0;
    while (clk_ref == lv && n < 40) begin tick(1); n++; end
    lv = clk_ref;
    n  = 0;
    do begin tick(1); n++; end while (clk_ref == lv && n < 40);
    check(name, n, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int snap;
    reset_n = 1'b0; prescale = 16'd3; fifo_clr = 1'b0; tx_wr = 1'b0; rx_rd = 1'b0;
    err_clr = 1'b0; tx_wdata = 8'h00; cpu_command = 4'h0; mast_iic_rw1 = 1'b0;
    master_rw_done = 1'b0; data_iicm_2_8032 = 8'h00;
    cur_data = 8'h00;
    model_clear();
    tick(3);
    check("rst_clk_ref", clk_ref, 0);
    check("rst_data", data_8032_2_iicm, 8'h00);
    check("rst_rel", rel_mst_rw, 0);
    check("rst_tx_level", tx_level, 0);
    check("rst_rx_level", rx_level, 0);
    check("rst_tx_full", tx_full, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_rx_rdata", rx_rdata, 8'h00);
    check("rst_flags", {tx_underrun, rx_overflow}, 2'b00);
    reset_n = 1'b1;

    // Divider
    meas_half(4, "div_half_p3_a");
    meas_half(4, "div_half_p3_b");
    prescale = 16'd0;
    tick(4);
    meas_half(1, "div_half_p0_a");
    meas_half(1, "div_half_p0_b");

    // Write stream
    push_tx(8'hA5);
    push_tx(8'h3C);
    check("tx_level_two", tx_level, 2);
    cpu_command = 4'b0001;
    strobe(20, 4, 8'h00);
    strobe(20, 4, 8'h00);
    strobe(20, 4, 8'h00);
    check("tx_data_held", data_8032_2_iicm, 8'h3C);
    check("underrun_set", tx_underrun, 1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0; uf_m = 1'b0;
    check("underrun_cleared", tx_underrun, 0);

    // Read stream
    cpu_command = 4'b0010;
    for (int i = 0; i <= DEPTH; i++) strobe(3, 2, 8'(i));
    check("rx_level_full", rx_level, 8);
    check("rx_overflow_set", rx_overflow, 1);
    check("rx_not_empty", rx_empty, 0);
    for (int i = 0; i < DEPTH; i++) begin
      rx_rd = 1'b1;
      tick(1);
      rx_lvl_m--;
    end
    rx_rd = 1'b0;
    check("rx_drained_empty", rx_empty, 1);
    check("rx_drained_rdata", rx_rdata, 8'h00);
    check("rx_drained_level", rx_level, 0);

    // Wrap with simultaneous push and pop
    cpu_command = 4'b0001;
    push_tx(8'h01);
    push_tx(8'h02);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cur_data = tx_model.pop_front();
      tx_exp.push_back({cur_data, uf_m});
      mast_iic_rw1 = 1'b1;
      tick(1);
      tx_wr = 1'b1;
      tx_wdata = 8'h10 + 8'(i);
      tx_model.push_back(tx_wdata);
      tick(1);
      tx_wr = 1'b0;
      mast_iic_rw1 = 1'b0;
      tick(1);
      check("wrap_level_const", tx_level, 2);
    end
    strobe(3, 2, 8'h00);
    strobe(3, 2, 8'h00);
    strobe(3, 2, 8'h00);
    check("wrap_last_byte", data_8032_2_iicm, 8'h27);

    // Release pulse
    snap = rel_cnt;
    master_rw_done = 1'b1;
    check("rel_not_yet", rel_mst_rw, 0);
    tick(1);
    check("rel_high", rel_mst_rw, 1);
    tick(1);
    check("rel_low_again", rel_mst_rw, 0);
    tick(48);
    master_rw_done = 1'b0;
    tick(3);
    check("rel_one_pulse", rel_cnt - snap, 1);

    // Flush with both FIFOs half full
    for (int i = 0; i < 4; i++) push_tx(8'h50 + 8'(i));
    cpu_command = 4'b0010;
    for (int i = 0; i < 4; i++) strobe(3, 2, 8'h60 + 8'(i));
    check("pre_flush_levels", {tx_level, rx_level}, {4'd4, 4'd4});
    check("pre_flush_flags", {tx_underrun, rx_overflow}, 2'b11);
    fifo_clr = 1'b1; tick(1); fifo_clr = 1'b0;
    model_clear();
    check("flush_levels", {tx_level, rx_level}, 8'h00);
    check("flush_flags", {tx_underrun, rx_overflow}, 2'b00);
    check("flush_data_kept", data_8032_2_iicm, 8'h27);
    check("flush_rx_empty", rx_empty, 1);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) push_tx(8'h70 + 8'(i));
    strobe(3, 2, 8'h80);
    strobe(3, 2, 8'h81);
    cpu_command = 4'b0000;
    mast_iic_rw1 = 1'b1;
    tick(3);
    reset_n = 1'b0;
    #2;
    model_clear();
    cur_data = 8'h00;
    check("mrst_clk_ref", clk_ref, 0);
    check("mrst_data", data_8032_2_iicm, 8'h00);
    check("mrst_levels", {tx_level, rx_level}, 8'h00);
    check("mrst_full_empty", {tx_full, rx_empty}, 2'b01);
    check("mrst_rx_rdata", rx_rdata, 8'h00);
    check("mrst_rel", rel_mst_rw, 0);
    mast_iic_rw1 = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    cpu_command = 4'b0001;
    strobe(3, 2, 8'h00);

    tick(4);
    check("tx_sb_drained", tx_exp.size(), 0);
    check("rx_sb_drained", rx_exp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
